// File: rtl/cluster_frame_collector_pkg.sv
// Shared definitions for the cluster frame collector.
// Holds the default field widths and the cluster word layout {vpf, cnt, adr}.
// Also holds the field offsets, the idle word and the pass-tracking FSM state codes.
package cluster_frame_collector_pkg;

  localparam int CL_MXKEYBITS = 8;
  localparam int CL_MXCNTB    = 3;

  // Cluster word layout at the default widths: {vpf, cnt, adr}
  localparam int CL_W       = 1 + CL_MXCNTB + CL_MXKEYBITS;
  localparam int CL_ADR_LSB = 0;
  localparam int CL_CNT_LSB = CL_MXKEYBITS;
  localparam int CL_VPF_BIT = CL_MXKEYBITS + CL_MXCNTB;

  // Empty slot: not valid, zero size, all-ones address
  localparam logic [CL_W-1:0] CL_IDLE = {1'b0, {CL_MXCNTB{1'b0}}, {CL_MXKEYBITS{1'b1}}};

  // Pass-tracking FSM states
  localparam logic [0:0] ST_HUNT    = 1'b0;
  localparam logic [0:0] ST_COLLECT = 1'b1;

endpackage

// File: rtl/cluster_slot_fill.sv
// Cluster slot accumulator for one frame.
// Appends valid candidates in arrival order and saturates at MXCLUSTERS, raising a sticky overflow bit.
// Ports:
//   clock, reset_n : clock, async active-low reset
//   restart        : treat the accumulator as empty before this cycle's write
//   wr, cand       : append cand this cycle
//   flush          : leave the accumulator empty after this cycle
//   slots_nxt, fill_nxt, ovf_nxt : accumulator contents including this cycle's write
module cluster_slot_fill #(
  parameter int MXCLUSTERS = 8,
  parameter int W          = 12,
  parameter int NCLB       = 4,
  parameter logic [W-1:0] IDLE = {W{1'b1}}
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    restart,
  input  logic                    wr,
  input  logic                    flush,
  input  logic [W-1:0]            cand,
  output logic [MXCLUSTERS*W-1:0] slots_nxt,
  output logic [NCLB-1:0]         fill_nxt,
  output logic                    ovf_nxt
);

  localparam logic [NCLB-1:0] FULL = NCLB'(MXCLUSTERS);

  logic [MXCLUSTERS*W-1:0] slots_r;
  logic [NCLB-1:0]         fill_r;
  logic                    ovf_r;
  logic [MXCLUSTERS*W-1:0] base_slots;
  logic [NCLB-1:0]         base_fill;
  logic                    base_ovf;

  // Next accumulator contents: optional restart, then saturating append
  always_comb begin
    base_slots = {MXCLUSTERS{IDLE}};
    base_fill  = {NCLB{1'b0}};
    base_ovf   = 1'b0;
    if (!restart) begin
      base_slots = slots_r;
      base_fill  = fill_r;
      base_ovf   = ovf_r;
    end else begin
      base_slots = {MXCLUSTERS{IDLE}};
    end
    slots_nxt = base_slots;
    fill_nxt  = base_fill;
    ovf_nxt   = base_ovf;
    if (wr) begin
      if (base_fill == FULL) begin
        // No room left: drop the candidate, remember the loss
        ovf_nxt = 1'b1;
      end else begin
        for (int k = 0; k < MXCLUSTERS; k++) begin
          if (base_fill == NCLB'(k)) begin
            slots_nxt[k*W +: W] = cand;
          end else begin
            slots_nxt[k*W +: W] = base_slots[k*W +: W];
          end
        end
        fill_nxt = base_fill + {{(NCLB-1){1'b0}}, 1'b1};
      end
    end else begin
      fill_nxt = base_fill;
    end
  end

  // Accumulator registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      slots_r <= {MXCLUSTERS{IDLE}};
      fill_r  <= {NCLB{1'b0}};
      ovf_r   <= 1'b0;
    end else if (flush) begin
      slots_r <= {MXCLUSTERS{IDLE}};
      fill_r  <= {NCLB{1'b0}};
      ovf_r   <= 1'b0;
    end else begin
      slots_r <= slots_nxt;
      fill_r  <= fill_nxt;
      ovf_r   <= ovf_nxt;
    end
  end

endmodule

// File: rtl/cluster_frame_collector.sv
// Groups NPASS consecutive encoder passes into one frame and packs the valid clusters into MXCLUSTERS slots.
// Ports:
//   clock, reset_n            : clock, async active-low reset
//   pass_i, vpf_i, adr_i, cnt_i : one encoder candidate per clock with its pass tag
//   clusters_o                : packed slots, slot k at [k*W +: W], word {vpf, cnt, adr}
//   ncl_o                     : number of valid slots in the presented frame
//   frame_valid_o             : one-clock strobe when a new frame is presented
//   overflow_o                : presented frame had more candidates than slots
//   sync_err_o                : one-clock strobe on a pass sequence violation
module cluster_frame_collector
  import cluster_frame_collector_pkg::*;
#(
  parameter int MXCLUSTERS = 8,
  parameter int MXKEYBITS  = CL_MXKEYBITS,
  parameter int MXCNTB     = CL_MXCNTB,
  parameter int NPASS      = 8,
  parameter int PASSB      = 3,
  parameter int NCLB       = 4
) (
  input  logic                                          clock,
  input  logic                                          reset_n,
  input  logic [PASSB-1:0]                              pass_i,
  input  logic                                          vpf_i,
  input  logic [MXKEYBITS-1:0]                          adr_i,
  input  logic [MXCNTB-1:0]                             cnt_i,
  output logic [MXCLUSTERS*(1+MXCNTB+MXKEYBITS)-1:0]    clusters_o,
  output logic [NCLB-1:0]                               ncl_o,
  output logic                                          frame_valid_o,
  output logic                                          overflow_o,
  output logic                                          sync_err_o
);

  localparam int W = 1 + MXCNTB + MXKEYBITS;
  localparam logic [W-1:0]     IDLE      = {1'b0, {MXCNTB{1'b0}}, {MXKEYBITS{1'b1}}};
  localparam logic [PASSB-1:0] PASS_ZERO = {PASSB{1'b0}};
  localparam logic [PASSB-1:0] PASS_ONE  = PASSB'(1);
  localparam logic [PASSB-1:0] PASS_LAST = PASSB'(NPASS - 1);

  logic [0:0]              state_r, state_nxt;
  logic [PASSB-1:0]        expected_r, expected_nxt;
  logic                    restart, wr, flush, frame_done, sync_err_nxt;
  logic [W-1:0]            cand;
  logic [MXCLUSTERS*W-1:0] slots_nxt;
  logic [NCLB-1:0]         fill_nxt;
  logic                    ovf_nxt;

  assign cand = {vpf_i, cnt_i, adr_i};

  cluster_slot_fill #(
    .MXCLUSTERS (MXCLUSTERS),
    .W          (W),
    .NCLB       (NCLB),
    .IDLE       (IDLE)
  ) u_slot_fill (
    .clock     (clock),
    .reset_n   (reset_n),
    .restart   (restart),
    .wr        (wr),
    .flush     (flush),
    .cand      (cand),
    .slots_nxt (slots_nxt),
    .fill_nxt  (fill_nxt),
    .ovf_nxt   (ovf_nxt)
  );

  // Pass tracking: decide accumulator action, frame completion and sync errors
  always_comb begin
    state_nxt    = state_r;
    expected_nxt = expected_r;
    restart      = 1'b0;
    wr           = 1'b0;
    flush        = 1'b0;
    frame_done   = 1'b0;
    sync_err_nxt = 1'b0;
    case (state_r)
      ST_HUNT: begin
        if (pass_i == PASS_ZERO) begin
          restart      = 1'b1;
          wr           = vpf_i;
          state_nxt    = ST_COLLECT;
          expected_nxt = PASS_ONE;
        end else begin
          state_nxt = ST_HUNT;
        end
      end
      ST_COLLECT: begin
        if (pass_i == expected_r) begin
          wr = vpf_i;
          if (pass_i == PASS_LAST) begin
            // Frame is published from the combinational view, so the accumulator can empty now
            frame_done   = 1'b1;
            flush        = 1'b1;
            state_nxt    = ST_HUNT;
            expected_nxt = PASS_ZERO;
          end else begin
            expected_nxt = expected_r + PASS_ONE;
          end
        end else begin
          sync_err_nxt = 1'b1;
          if (pass_i == PASS_ZERO) begin
            // Out-of-order pass 0 is itself a valid frame start
            restart      = 1'b1;
            wr           = vpf_i;
            expected_nxt = PASS_ONE;
          end else begin
            flush        = 1'b1;
            state_nxt    = ST_HUNT;
            expected_nxt = PASS_ZERO;
          end
        end
      end
      default: begin
        flush        = 1'b1;
        state_nxt    = ST_HUNT;
        expected_nxt = PASS_ZERO;
      end
    endcase
  end

  // FSM state and expected pass tag
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_HUNT;
      expected_r <= PASS_ZERO;
    end else begin
      state_r    <= state_nxt;
      expected_r <= expected_nxt;
    end
  end

  // Output registers: frame fields hold between completed frames, strobes last one clock
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      clusters_o    <= {MXCLUSTERS{IDLE}};
      ncl_o         <= {NCLB{1'b0}};
      overflow_o    <= 1'b0;
      frame_valid_o <= 1'b0;
      sync_err_o    <= 1'b0;
    end else begin
      if (frame_done) begin
        clusters_o <= slots_nxt;
        ncl_o      <= fill_nxt;
        overflow_o <= ovf_nxt;
      end
      frame_valid_o <= frame_done;
      sync_err_o    <= sync_err_nxt;
    end
  end

endmodule

// File: doc/cluster_frame_collector.md
Name: cluster_frame_collector

Overview:
- Sits directly downstream of the 192-pad priority encoder.
- The encoder presents one cluster candidate per clock, tagged with a pass number (vpf, adr, cnt, pass).
- This block groups NPASS consecutive passes into one bunch-crossing frame and packs the valid clusters, in arrival order, into MXCLUSTERS output slots.
- It then presents the completed frame, with a valid-cluster count and overflow/sync flags, to the trigger link formatter.

Parameters:
- MXCLUSTERS, 8, number of output cluster slots per frame.
- MXKEYBITS, 8, width of the cluster address.
- MXCNTB, 3, width of the cluster size count.
- NPASS, 8, passes per frame; legal range 2..2**PASSB.
- PASSB, 3, width of the pass tag.
- NCLB, 4, width of the cluster count; must hold MXCLUSTERS.

Ports:
- clock  in  1  design clock; every pass arrives on it.
- reset_n  in  1  reset, asynchronous and active-low.
- pass_i  in  PASSB  pass tag aligned with the candidate.
- vpf_i  in  1  candidate valid.
- adr_i  in  MXKEYBITS  candidate pad address.
- cnt_i  in  MXCNTB  candidate cluster size.
- clusters_o  out  MXCLUSTERS*(1+MXCNTB+MXKEYBITS)  packed slots.
  - Slot k occupies bits [k*W +: W], with W = 1+MXCNTB+MXKEYBITS.
  - Slot word format is {vpf, cnt, adr}.
- ncl_o  out  NCLB  number of valid slots in the presented frame.
- frame_valid_o  out  1  one-clock strobe: new frame on clusters_o.
- overflow_o  out  1  presented frame had more than MXCLUSTERS valid candidates.
- sync_err_o  out  1  one-clock strobe: pass sequence violation detected.

Behaviour:
- Reset values, asynchronous on reset_n low:
  - clusters_o: every slot = {0, 0, all-ones adr}.
  - ncl_o = 0; frame_valid_o = 0; overflow_o = 0; sync_err_o = 0.
  - State = HUNT; expected pass = 0; accumulator slots = idle word.
- Inputs are sampled on the rising edge of clock.
- State machine (two states):
  - HUNT:
    - Sampled pass_i == 0: go to COLLECT. Load the accumulator from this sample (slot 0 if vpf_i, otherwise empty). Expected pass = 1.
    - Otherwise: stay in HUNT with no output activity.
  - COLLECT:
    - Sampled pass_i == expected: if vpf_i, write the candidate to slot[fill] and increment fill.
    - If fill == MXCLUSTERS already, drop the candidate and set the sticky frame overflow bit.
    - Then increment expected.
- Frame completion:
  - On the edge that samples pass_i == NPASS-1 in COLLECT, the registered outputs take the assembled frame, including the current sample.
  - Output values: unused slots = idle word; ncl_o = fill; overflow_o = sticky bit; frame_valid_o = 1 for one clock.
  - Next state = HUNT-equivalent: accumulator cleared, expected = 0, so the next pass 0 starts a new frame back to back.
  - Latency: frame_valid_o rises one clock after the last-pass sample.
- Output hold: clusters_o, ncl_o and overflow_o hold their values until the next completed frame.
- Sync error: in COLLECT, sampled pass_i != expected:
  - sync_err_o pulses for 1 clock; the partial frame is discarded with no frame_valid_o.
  - If pass_i == 0, a new frame starts with this sample (COLLECT, expected = 1); otherwise go to HUNT.
- Ordering: slot order equals arrival order. Slot 0 is the first valid candidate of the frame, which is the lowest address when the encoder masks found clusters.
- Invalid candidates (vpf_i = 0): adr_i and cnt_i are ignored; they never occupy a slot.
- Reset mid-frame: the partial frame is lost and outputs return to reset values immediately.
- No backpressure: the consumer must accept every frame_valid_o strobe.

Decomposition:
- Shared cluster package holds:
  - cluster word width W and the field offsets for vpf, cnt and adr;
  - the idle cluster word constant {0, 0, all-ones};
  - MXKEYBITS and MXCNTB defaults.
- One sub-module is natural: cluster_slot_fill.
  - Holds the accumulator registers and the fill counter with its saturating write.
  - Has a clear input.
  - The top level keeps the pass-tracking FSM and the output registers.

Test Plan:
- Reset then all-invalid frame: passes 0..7 with vpf = 0 → one frame_valid_o strobe, ncl_o = 0, all slots idle (adr = 0xFF), overflow_o = 0.
- Three clusters: pass 1 {adr 0x05, cnt 2}, pass 2 {0x40, 0}, pass 6 {0xBF, 7}, others invalid → slot0 = {1,2,0x05}, slot1 = {1,0,0x40}, slot2 = {1,7,0xBF}, ncl_o = 3, frame_valid_o one clock after the pass-7 sample.
- Overflow with MXCLUSTERS = 4 and NPASS = 8: all 8 passes valid with adr 0..7 → slots hold adr 0..3, ncl_o = 4, overflow_o = 1. Next clean frame → overflow_o = 0.
- Sync error: passes 0, 1, 3 → sync_err_o pulses on the pass-3 sample and no frame is emitted. HUNT ignores passes 4..7; the next 0..7 sequence produces a normal frame.
- Back-to-back frames: two consecutive 0..7 sequences with distinct clusters → two frame_valid_o strobes 8 clocks apart, and the second frame contains no residue from the first.
- Async reset asserted at pass 4 of a frame with 2 clusters collected → outputs go to reset values immediately with no strobe. After release, a full 0..7 sequence yields a frame containing only the new clusters.
